// File: rtl/aixh_mxc_left_dwd_issuer_pkg.sv
// Shared MxConv types for the left-side dwd issuer: FSM state, dwd command layout
// and the LP-cell bus width tie-ins.
package AIXH_MXC_pkg;

  localparam int LPCELL_DWD_OPW    = 4;
  localparam int LPCELL_DWD_DWIDTH = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } mxc_state_e;

  typedef struct packed {
    logic [LPCELL_DWD_OPW-1:0] op;
    logic                      first;
    logic                      last;
  } dwd_cmd_t;

  localparam int LPCELL_DWD_CWIDTH = $bits(dwd_cmd_t);

  function automatic dwd_cmd_t dwd_cmd_pack(input logic [LPCELL_DWD_OPW-1:0] op,
                                            input logic first,
                                            input logic last);
    dwd_cmd_t c;
    c.op    = op;
    c.first = first;
    c.last  = last;
    return c;
  endfunction

endpackage

// File: rtl/aixh_mxc_left_dwd_issuer_if.sv
// Descriptor, source-stream and dwd-bus signals of the left dwd issuer.
// master = traffic source / bus observer, slave = the issuer.
interface aixh_mxc_left_dwd_issuer_if #(
  parameter int OPW    = 4,
  parameter int DWIDTH = 256,
  parameter int LENW   = 12
);
  logic              i_desc_vld;
  logic              o_desc_rdy;
  logic [OPW-1:0]    i_desc_op;
  logic [LENW-1:0]   i_desc_len;
  logic              i_src_vld;
  logic              o_src_rdy;
  logic [DWIDTH-1:0] i_src_dat;
  logic [OPW+1:0]    o_dwd_cmd;
  logic              o_dwd_vld;
  logic [DWIDTH-1:0] o_dwd_dat;

  modport master (
    output i_desc_vld, i_desc_op, i_desc_len, i_src_vld, i_src_dat,
    input  o_desc_rdy, o_src_rdy, o_dwd_cmd, o_dwd_vld, o_dwd_dat
  );

  modport slave (
    input  i_desc_vld, i_desc_op, i_desc_len, i_src_vld, i_src_dat,
    output o_desc_rdy, o_src_rdy, o_dwd_cmd, o_dwd_vld, o_dwd_dat
  );
endinterface

// File: rtl/aixh_mxc_left_dwd_issuer_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module aixh_mxc_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/aixh_mxc_left_dwd_issuer.sv
// Head-of-chain issuer for the MxConv left dwd repeater bus: turns descriptors plus a
// source stream into registered, first/last-tagged dwd beats with a post-transfer idle gap.
// Optional perf counters under `AIXH_MXC_LEFT_ISSUER_PERF_EN.
module aixh_mxc_left_dwd_issuer
  import AIXH_MXC_pkg::*;
#(
  parameter int OPW     = LPCELL_DWD_OPW,
  parameter int DWIDTH  = LPCELL_DWD_DWIDTH,
  parameter int LENW    = 12,
  parameter int MIN_GAP = 2
) (
  input  logic                        aixh_core_clk2x,
  input  logic                        aixh_core_rst2x,
  aixh_mxc_left_dwd_issuer_if.slave   bus,
  input  logic                        i_abort,
  output logic                        o_busy
`ifdef AIXH_MXC_LEFT_ISSUER_PERF_EN
  ,
  input  logic                        i_perf_clr,
  output logic [31:0]                 o_perf_stall,
  output logic [31:0]                 o_perf_beats
`endif
);

  localparam int GAPW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAPW-1:0] GAP_LAST = GAPW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

  mxc_state_e        state_q, state_d;
  logic [OPW-1:0]    op_q, op_d;
  logic [LENW-1:0]   rem_q, rem_d;
  logic              first_pend_q, first_pend_d;
  logic              desc_rdy_q, src_rdy_q, busy_q;
  logic              dwd_vld_q, dwd_vld_d;
  logic [OPW+1:0]    dwd_cmd_q, dwd_cmd_d;
  logic [DWIDTH-1:0] dwd_dat_q, dwd_dat_d;

  logic              desc_fire_s, beat_fire_s, last_beat_s;
  logic              gap_clr_s, gap_done_s;
  logic [GAPW-1:0]   gap_cnt_s;

  // Handshakes only use the registered readies, so no input reaches a ready output.
  assign desc_fire_s = bus.i_desc_vld & desc_rdy_q;
  assign beat_fire_s = bus.i_src_vld & src_rdy_q;
  assign last_beat_s = (rem_q == LENW'(1));
  assign gap_done_s  = (state_q == GAP) && (gap_cnt_s == GAP_LAST);
  assign gap_clr_s   = (state_q != GAP) || gap_done_s;

  aixh_mxc_sat_counter #(.W(GAPW)) u_gap_cnt (
    .clk_i (aixh_core_clk2x),
    .rst_i (aixh_core_rst2x),
    .inc_i (state_q == GAP),
    .clr_i (gap_clr_s),
    .cnt_o (gap_cnt_s)
  );

  // Next-state and dwd beat formation.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rem_d        = rem_q;
    first_pend_d = first_pend_q;
    dwd_vld_d    = 1'b0;
    dwd_cmd_d    = '0;
    dwd_dat_d    = dwd_dat_q;
    case (state_q)
      IDLE: begin
        if (desc_fire_s && (bus.i_desc_len != '0)) begin
          op_d         = bus.i_desc_op;
          rem_d        = bus.i_desc_len;
          first_pend_d = 1'b1;
          state_d      = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (beat_fire_s) begin
          dwd_vld_d    = 1'b1;
          dwd_dat_d    = bus.i_src_dat;
          dwd_cmd_d    = {op_q, first_pend_q, last_beat_s};
          first_pend_d = 1'b0;
          rem_d        = last_beat_s ? rem_q : rem_q - LENW'(1);
        end else begin
          rem_d = rem_q;
        end
        // Abort also skips the gap, even when it lands on the last beat.
        if (i_abort) begin
          state_d = IDLE;
        end else if (beat_fire_s && last_beat_s) begin
          state_d = (MIN_GAP > 0) ? GAP : IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      GAP: begin
        if (gap_done_s) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, transfer context and registered outputs.
  always_ff @(posedge aixh_core_clk2x or posedge aixh_core_rst2x) begin
    if (aixh_core_rst2x) begin
      state_q      <= IDLE;
      op_q         <= '0;
      rem_q        <= '0;
      first_pend_q <= 1'b0;
      desc_rdy_q   <= 1'b0;
      src_rdy_q    <= 1'b0;
      busy_q       <= 1'b0;
      dwd_vld_q    <= 1'b0;
      dwd_cmd_q    <= '0;
      dwd_dat_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rem_q        <= rem_d;
      first_pend_q <= first_pend_d;
      desc_rdy_q   <= (state_d == IDLE);
      src_rdy_q    <= (state_d == ISSUE);
      busy_q       <= (state_d != IDLE);
      dwd_vld_q    <= dwd_vld_d;
      dwd_cmd_q    <= dwd_cmd_d;
      dwd_dat_q    <= dwd_dat_d;
    end
  end

  assign bus.o_desc_rdy = desc_rdy_q;
  assign bus.o_src_rdy  = src_rdy_q;
  assign bus.o_dwd_vld  = dwd_vld_q;
  assign bus.o_dwd_cmd  = dwd_cmd_q;
  assign bus.o_dwd_dat  = dwd_dat_q;
  assign o_busy         = busy_q;

`ifdef AIXH_MXC_LEFT_ISSUER_PERF_EN
  aixh_mxc_sat_counter #(.W(32)) u_perf_stall (
    .clk_i (aixh_core_clk2x),
    .rst_i (aixh_core_rst2x),
    .inc_i ((state_q == ISSUE) && !bus.i_src_vld),
    .clr_i (i_perf_clr),
    .cnt_o (o_perf_stall)
  );

  aixh_mxc_sat_counter #(.W(32)) u_perf_beats (
    .clk_i (aixh_core_clk2x),
    .rst_i (aixh_core_rst2x),
    .inc_i (beat_fire_s),
    .clr_i (i_perf_clr),
    .cnt_o (o_perf_beats)
  );
`endif

endmodule

// File: doc/aixh_mxc_left_dwd_issuer.md
Name: aixh_mxc_left_dwd_issuer

Overview:
- Feeds the head of the MxConv left-side downward (dwd) repeater chain.
- Accepts per-transfer descriptors (op code, beat count) on a valid/ready port and pulls data beats from a valid/ready source stream.
- Emits registered cmd/vld/dat beats on the dwd bus, which has no backpressure.
- Tags first/last beats and enforces a minimum idle gap between transfers so LP cells can turn around.

Parameters:
- OPW, default 4: op-code width.
- DWIDTH, default 256: dwd data width; must equal LPCELL_DWD_DWIDTH.
- LENW, default 12: beat-count width.
- MIN_GAP, default 2: idle cycles forced after each transfer's last beat. 0 means no gap.

Ports:
- aixh_core_clk2x  in  1  sole clock.
- aixh_core_rst2x  in  1  asynchronous, active-high reset.
- i_desc_vld  in  1  descriptor valid.
- o_desc_rdy  out  1  descriptor ready.
- i_desc_op  in  OPW  op code for all beats of the transfer.
- i_desc_len  in  LENW  beat count; 0 is a no-op.
- i_src_vld  in  1  source beat valid.
- o_src_rdy  out  1  source beat ready.
- i_src_dat  in  DWIDTH  source beat data.
- i_abort  in  1  terminate the current transfer.
- o_dwd_cmd  out  OPW+2  {op, first, last}; equals LPCELL_DWD_CWIDTH.
- o_dwd_vld  out  1  dwd beat valid.
- o_dwd_dat  out  DWIDTH  dwd beat data.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; beat counter 0; gap counter 0.
- One clock (aixh_core_clk2x); reset is asynchronous and active-high (aixh_core_rst2x).
- States: IDLE, ISSUE, GAP.
- IDLE:
  - o_desc_rdy=1, o_src_rdy=0.
  - Descriptor accept with len!=0: latch op and len, load remaining=len, set first_pend=1, go to ISSUE.
  - Descriptor accept with len==0: consumed, nothing emitted, stay IDLE.
- ISSUE:
  - o_desc_rdy=0, o_src_rdy=1. Both ready signals are registered-state decodes only; no combinational path from inputs.
  - Beat fire = i_src_vld & o_src_rdy.
  - On fire: o_dwd_vld<=1, o_dwd_dat<=i_src_dat, o_dwd_cmd<={op, first_pend, remaining==1}; first_pend<=0; remaining<=remaining-1.
  - Fire with remaining==1: go to GAP (MIN_GAP>0) or IDLE (MIN_GAP==0).
  - Source bubbles (i_src_vld=0) insert o_dwd_vld=0 cycles; the transfer continues.
- GAP: counts MIN_GAP cycles, then IDLE. Neither port is ready.
- Latency: source beat accepted in cycle t appears on o_dwd_* at t+1.
- Idle cycles: o_dwd_vld=0 and o_dwd_cmd=0 (NOP). o_dwd_dat holds its last value and is updated only on fire, to save toggle power.
- Back-to-back: with MIN_GAP==0, the cycle after the last beat is IDLE (desc accept), so successive transfers have at least 1 bubble.
- Single-beat transfer (len==1): first=last=1 on the same beat.
- Abort:
  - i_abort in ISSUE: a beat firing in the same cycle is still emitted with its normal flags; the next state is IDLE (GAP skipped), and remaining beats are not pulled.
  - i_abort in IDLE or GAP: ignored.
- Reset mid-transfer: immediate return to IDLE; o_dwd_vld drops asynchronously; no partial last flag is emitted.
- Arithmetic: remaining is LENW bits and never decrements below 1 while in ISSUE. Maximum len is 2^LENW-1.

Optional Feature:
- Macro: AIXH_MXC_LEFT_ISSUER_PERF_EN.
- Defined:
  - Adds o_perf_stall (out, 32): cycles spent in ISSUE with i_src_vld=0.
  - Adds o_perf_beats (out, 32): total fired beats.
  - Both reset to 0, saturate at all-ones, and are cleared by i_perf_clr (in, 1); clear takes priority over increment.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package AIXH_MXC_pkg:
  - enum state type (IDLE/ISSUE/GAP).
  - dwd cmd struct {op, first, last} and its cmd-width constant.
  - LPCELL_DWD_CWIDTH/DWIDTH tie-in.
- Sub-module aixh_mxc_sat_counter (parameterised width, inc/clr, saturating), instantiated twice under the perf macro.

Test Plan:
- Reset, then desc op=3, len=4, source always valid with data 0xA0..0xA3:
  - 4 consecutive o_dwd_vld beats, starting 1 cycle after the first src accept.
  - cmd flags f/l = 10, 00, 00, 01; op=3 on every beat.
  - Then 2 GAP cycles with o_desc_rdy=0.
- len=1, op=7: a single beat with cmd={7,1,1}; o_busy falls after MIN_GAP+1 cycles.
- len=0 descriptor: accepted in 1 cycle; no o_dwd_vld; o_busy never rises.
- len=5 with source bubbles on beats 2 and 4:
  - o_dwd_vld shows the matching gaps.
  - o_dwd_dat holds its previous value during the gaps.
  - last flag set only on the 5th beat.
  - perf stall count = 2 when the macro is defined.
- len=8, i_abort asserted concurrent with the 3rd beat fire:
  - 3 beats emitted, none with last=1.
  - IDLE the next cycle, o_desc_rdy=1, no GAP.
- Async reset asserted mid-transfer, between clock edges:
  - All outputs go to 0 without waiting for a clock edge.
  - A new len=2 descriptor then completes normally with correct first/last flags.
